// File: rtl/multiply_unit_pkg.sv
// Shared core package: M-extension ALU control codes and the multiply FSM state enum.
// Used by the ALU decoder and by multiply_unit.
package multiply_unit_pkg;

  localparam int unsigned ALU_CTRL_W = 5;

  // M-extension control codes produced by the ALU decoder
  localparam logic [ALU_CTRL_W-1:0] ALU_MUL    = 5'b01111;
  localparam logic [ALU_CTRL_W-1:0] ALU_MULH   = 5'b10000;
  localparam logic [ALU_CTRL_W-1:0] ALU_MULHSU = 5'b10001;
  localparam logic [ALU_CTRL_W-1:0] ALU_MULHU  = 5'b10010;
  localparam logic [ALU_CTRL_W-1:0] ALU_MULW   = 5'b10111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  // True for any control code the multiply unit executes
  function automatic logic is_mul_op(input logic [ALU_CTRL_W-1:0] code);
    return (code == ALU_MUL)    || (code == ALU_MULH)  ||
           (code == ALU_MULHSU) || (code == ALU_MULHU) ||
           (code == ALU_MULW);
  endfunction

endpackage

// File: rtl/multiply_unit_mul_operand_prep.sv
// mul_operand_prep: combinational sign handling for the shift-add multiplier.
// Produces unsigned operand magnitudes and the flag that says the final
// product must be negated.
//   alu_control : multiply control code
//   src_a/src_b : raw operands (MULW uses only bits [31:0], sign-extended)
//   mag_a/mag_b : operand magnitudes; the most-negative value maps to 2^(XLEN-1)
//   negate      : exactly one signed-treated operand was negative
module mul_operand_prep
  import multiply_unit_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [ALU_CTRL_W-1:0] alu_control,
  input  logic [XLEN-1:0]       src_a,
  input  logic [XLEN-1:0]       src_b,
  output logic [XLEN-1:0]       mag_a,
  output logic [XLEN-1:0]       mag_b,
  output logic                  negate
);

  logic [XLEN-1:0] a_ext;
  logic [XLEN-1:0] b_ext;
  logic            a_signed;
  logic            b_signed;
  logic            neg_a;
  logic            neg_b;

  // Operand view and signedness per control code
  always_comb begin
    a_ext    = src_a;
    b_ext    = src_b;
    a_signed = 1'b1;
    b_signed = 1'b1;
    case (alu_control)
      ALU_MULHSU: b_signed = 1'b0;
      ALU_MULHU: begin
        a_signed = 1'b0;
        b_signed = 1'b0;
      end
      ALU_MULW: begin
        a_ext = {{(XLEN-32){src_a[31]}}, src_a[31:0]};
        b_ext = {{(XLEN-32){src_b[31]}}, src_b[31:0]};
      end
      default: ;
    endcase
  end

  // Two's-complement negation of the most-negative value yields the same
  // bit pattern, which read as unsigned is exactly the required magnitude.
  always_comb begin
    neg_a  = a_signed & a_ext[XLEN-1];
    neg_b  = b_signed & b_ext[XLEN-1];
    mag_a  = neg_a ? (~a_ext + XLEN'(1)) : a_ext;
    mag_b  = neg_b ? (~b_ext + XLEN'(1)) : b_ext;
    negate = neg_a ^ neg_b;
  end

endmodule

// File: rtl/multiply_unit.sv
// multiply_unit: iterative radix-2 shift-add multiplier for the M extension.
// One multiplier bit per cycle into a 2*XLEN accumulator; XLEN iterations
// (32 for MULW), then a final sign correction and result selection.
//   clk_i/rst_ni        : clock, synchronous active-low reset
//   valid_i             : request presented by execute stage
//   alu_control_i       : control code (MUL/MULH/MULHSU/MULHU/MULW)
//   src_a_i/src_b_i     : operands rs1/rs2
//   flush_i             : abort any in-flight operation
//   stall_i             : hold a completed result in DONE
//   ready_o             : unit can accept a request (IDLE)
//   busy_o              : operation in flight (BUSY, or DONE under stall)
//   valid_o             : result_o holds a completed product
//   result_o            : multiply result, zero when valid_o is low
module multiply_unit
  import multiply_unit_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  input  logic [ALU_CTRL_W-1:0] alu_control_i,
  input  logic [XLEN-1:0]       src_a_i,
  input  logic [XLEN-1:0]       src_b_i,
  input  logic                  flush_i,
  input  logic                  stall_i,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [XLEN-1:0]       result_o
);

  localparam int unsigned CNT_W  = $clog2(XLEN) + 1;
  localparam int unsigned PROD_W = 2 * XLEN;

  mul_state_e              state_q;
  mul_state_e              state_d;

  logic [CNT_W-1:0]        cnt_q;
  logic [PROD_W-1:0]       acc_q;
  logic [PROD_W-1:0]       mcand_q;
  logic [XLEN-1:0]         mplier_q;
  logic                    negate_q;
  logic [ALU_CTRL_W-1:0]   op_q;
  logic [XLEN-1:0]         result_q;

  logic [XLEN-1:0]         mag_a;
  logic [XLEN-1:0]         mag_b;
  logic                    negate;
  logic                    accept;
  logic                    last_iter;
  logic [CNT_W-1:0]        n_iter;
  logic [PROD_W-1:0]       acc_next;
  logic [PROD_W-1:0]       prod_fin;
  logic [XLEN-1:0]         result_sel;

  mul_operand_prep #(
    .XLEN (XLEN)
  ) u_prep (
    .alu_control (alu_control_i),
    .src_a       (src_a_i),
    .src_b       (src_b_i),
    .mag_a       (mag_a),
    .mag_b       (mag_b),
    .negate      (negate)
  );

  // Request handshake and iteration bookkeeping
  always_comb begin
    accept    = valid_i && (state_q == IDLE) && is_mul_op(alu_control_i) && !flush_i;
    last_iter = (state_q == BUSY) && (cnt_q == CNT_W'(1));
    n_iter    = (alu_control_i == ALU_MULW) ? CNT_W'(32) : CNT_W'(XLEN);
  end

  // One shift-add step, sign correction and result selection
  always_comb begin
    acc_next   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    prod_fin   = negate_q ? (~acc_next + PROD_W'(1)) : acc_next;
    result_sel = prod_fin[XLEN-1:0];
    case (op_q)
      ALU_MULH, ALU_MULHSU, ALU_MULHU: result_sel = prod_fin[PROD_W-1:XLEN];
      ALU_MULW: result_sel = {{(XLEN-32){prod_fin[31]}}, prod_fin[31:0]};
      default: ;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and status outputs
  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    busy_o  = 1'b0;
    valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (accept) state_d = BUSY;
      end
      BUSY: begin
        busy_o = 1'b1;
        if (flush_i)        state_d = IDLE;
        else if (last_iter) state_d = DONE;
      end
      DONE: begin
        valid_o = 1'b1;
        busy_o  = stall_i;
        if (flush_i || !stall_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand latch at accept, one iteration per BUSY cycle
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      negate_q <= 1'b0;
      op_q     <= '0;
    end else if (accept) begin
      cnt_q    <= n_iter;
      acc_q    <= '0;
      mcand_q  <= {{XLEN{1'b0}}, mag_a};
      mplier_q <= mag_b;
      negate_q <= negate;
      op_q     <= alu_control_i;
    end else if ((state_q == BUSY) && !flush_i) begin
      cnt_q    <= cnt_q - CNT_W'(1);
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

  // Result register: loaded on entry to DONE, held there, zero elsewhere
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      result_q <= '0;
    end else if ((state_q == BUSY) && (state_d == DONE)) begin
      result_q <= result_sel;
    end else if (state_d != DONE) begin
      result_q <= '0;
    end
  end

  assign result_o = result_q;

endmodule

// File: tb/tb_multiply_unit.sv
// Self-checking bench for multiply_unit (XLEN=64): scoreboard of expected
// products, latency, handshake, flush, stall and reset behaviour.
module tb_multiply_unit;
  import multiply_unit_pkg::*;

  localparam int unsigned XLEN = 64;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            valid_i;
  logic [4:0]      alu_control_i;
  logic [XLEN-1:0] src_a_i;
  logic [XLEN-1:0] src_b_i;
  logic            flush_i;
  logic            stall_i;
  logic            ready_o;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int rise_cnt = 0;
  int zero_bad = 0;
  logic prev_valid = 1'b0;
  logic [63:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  multiply_unit #(.XLEN(XLEN)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .valid_i       (valid_i),
    .alu_control_i (alu_control_i),
    .src_a_i       (src_a_i),
    .src_b_i       (src_b_i),
    .flush_i       (flush_i),
    .stall_i       (stall_i),
    .ready_o       (ready_o),
    .busy_o        (busy_o),
    .valid_o       (valid_o),
    .result_o      (result_o)
  );

  // Count valid_o rising edges and any nonzero result outside DONE
  always @(negedge clk_i) begin
    if (valid_o === 1'b1 && !prev_valid) rise_cnt <= rise_cnt + 1;
    prev_valid <= (valid_o === 1'b1);
    if (rst_ni === 1'b1 && valid_o !== 1'b1 && result_o !== 64'd0) zero_bad <= zero_bad + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference product via wide two's-complement arithmetic
  function automatic logic [63:0] model(input logic [4:0] op, input logic [63:0] a,
                                        input logic [63:0] b);
    logic [129:0] ea;
    logic [129:0] eb;
    logic [129:0] p;
    ea = {{66{a[63]}}, a};
    eb = {{66{b[63]}}, b};
    if (op == ALU_MULHSU) eb = {66'd0, b};
    if (op == ALU_MULHU) begin
      ea = {66'd0, a};
      eb = {66'd0, b};
    end
    if (op == ALU_MULW) begin
      ea = {{98{a[31]}}, a[31:0]};
      eb = {{98{b[31]}}, b[31:0]};
    end
    p = ea * eb;
    case (op)
      ALU_MUL:  return p[63:0];
      ALU_MULW: return {{32{p[31]}}, p[31:0]};
      default:  return p[127:64];
    endcase
  endfunction

  // Issue one request from IDLE, wait for completion, check latency/result,
  // optionally hold DONE with stall_i and drive ignored requests while busy.
  task automatic do_op(input string tag, input logic [4:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input int n,
                       input int stall_cyc, input bit noise);
    int cyc;
    logic [63:0] e;
    valid_i       = 1'b1;
    alu_control_i = op;
    src_a_i       = a;
    src_b_i       = b;
    stall_i       = (stall_cyc > 0);
    exp_q.push_back(exp);
    tick();
    valid_i = noise;
    if (noise) begin
      alu_control_i = ALU_MULHU;
      src_a_i       = {$urandom, $urandom};
      src_b_i       = {$urandom, $urandom};
    end
    check_eq({tag, "_busy"}, 64'(busy_o), 64'd1);
    cyc = 0;
    while (valid_o !== 1'b1 && cyc < n + 10) begin
      tick();
      cyc++;
    end
    valid_i = 1'b0;
    check_eq({tag, "_latency"}, 64'(cyc), 64'(n));
    e = exp_q.pop_front();
    if (valid_o === 1'b1) begin
      done_cnt++;
      for (int d = 1; d <= stall_cyc + 1; d++) begin
        stall_i = (d <= stall_cyc);
        #1;
        check_eq({tag, "_valid"}, 64'(valid_o), 64'd1);
        check_eq({tag, "_result"}, result_o, e);
        check_eq({tag, "_busy_done"}, 64'(busy_o), 64'(d <= stall_cyc));
        tick();
      end
      check_eq({tag, "_valid_after"}, 64'(valid_o), 64'd0);
      check_eq({tag, "_ready_after"}, 64'(ready_o), 64'd1);
    end
    stall_i = 1'b0;
  endtask

  logic [4:0] bad_codes[3];
  logic [4:0] ops[5];

  initial begin
    rst_ni        = 1'b0;
    valid_i       = 1'b0;
    alu_control_i = '0;
    src_a_i       = '0;
    src_b_i       = '0;
    flush_i       = 1'b0;
    stall_i       = 1'b0;
    bad_codes     = '{5'b00000, 5'b10011, 5'b01110};
    ops           = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_MULW};

    repeat (2) tick();
    check_eq("rst_ready", 64'(ready_o), 64'd1);
    check_eq("rst_busy", 64'(busy_o), 64'd0);
    check_eq("rst_valid", 64'(valid_o), 64'd0);
    check_eq("rst_result", result_o, 64'd0);
    rst_ni = 1'b1;
    tick();

    // Directed products
    do_op("mul_3_m5", ALU_MUL, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 64, 0, 1'b0);
    do_op("mulh_minneg", ALU_MULH, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
          64'h4000_0000_0000_0000, 64, 0, 1'b0);
    do_op("mulhu_ones", ALU_MULHU, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 64, 0, 1'b0);
    do_op("mulhsu_ones", ALU_MULHSU, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 64, 0, 1'b1);
    do_op("mulw_7fff", ALU_MULW, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 32, 0, 1'b0);
    do_op("mul_zero", ALU_MUL, 64'd0, 64'd0, 64'd0, 64, 0, 1'b0);
    do_op("mulw_hi_ignored", ALU_MULW, 64'hDEAD_BEEF_FFFF_FFFD, 64'h1234_5678_0000_0007,
          64'hFFFF_FFFF_FFFF_FFEB, 32, 0, 1'b1);

    // Stall holds DONE for four cycles
    do_op("stall3", ALU_MUL, 64'd1000, 64'd7, 64'd7000, 64, 3, 1'b0);

    // Random operands against the wide model
    for (int i = 0; i < 6; i++) begin
      logic [4:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      op = ops[$urandom_range(0, 4)];
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      do_op("rand", op, a, b, model(op, a, b), (op == ALU_MULW) ? 32 : 64, i % 2, 1'b1);
    end

    // Unsupported codes are not accepted
    foreach (bad_codes[i]) begin
      valid_i       = 1'b1;
      alu_control_i = bad_codes[i];
      tick();
      valid_i = 1'b0;
      check_eq("bad_code_ready", 64'(ready_o), 64'd1);
      check_eq("bad_code_busy", 64'(busy_o), 64'd0);
    end

    // Flush wins over accept in the same cycle
    valid_i       = 1'b1;
    alu_control_i = ALU_MUL;
    flush_i       = 1'b1;
    tick();
    valid_i = 1'b0;
    flush_i = 1'b0;
    check_eq("flush_prio_ready", 64'(ready_o), 64'd1);

    // Flush in cycle 10 of BUSY, then a fresh request completes
    valid_i       = 1'b1;
    alu_control_i = ALU_MUL;
    src_a_i       = 64'd11;
    src_b_i       = 64'd13;
    tick();
    valid_i = 1'b0;
    repeat (9) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check_eq("flush_busy_ready", 64'(ready_o), 64'd1);
    check_eq("flush_busy_valid", 64'(valid_o), 64'd0);
    check_eq("flush_busy_busy", 64'(busy_o), 64'd0);
    do_op("after_flush", ALU_MULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64, 0, 1'b0);

    // Flush while stalled in DONE drops the result
    valid_i       = 1'b1;
    alu_control_i = ALU_MULW;
    src_a_i       = 64'd6;
    src_b_i       = 64'd9;
    stall_i       = 1'b1;
    tick();
    valid_i = 1'b0;
    begin
      int cyc;
      cyc = 0;
      while (valid_o !== 1'b1 && cyc < 50) begin
        tick();
        cyc++;
      end
      check_eq("flush_done_latency", 64'(cyc), 64'd32);
      if (valid_o === 1'b1) done_cnt++;
    end
    check_eq("flush_done_result", result_o, 64'd54);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    stall_i = 1'b0;
    check_eq("flush_done_valid", 64'(valid_o), 64'd0);
    check_eq("flush_done_ready", 64'(ready_o), 64'd1);

    // Reset mid-BUSY discards the operation
    valid_i       = 1'b1;
    alu_control_i = ALU_MUL;
    src_a_i       = 64'd3;
    src_b_i       = 64'd4;
    tick();
    valid_i = 1'b0;
    repeat (5) tick();
    rst_ni = 1'b0;
    tick();
    check_eq("rst_mid_ready", 64'(ready_o), 64'd1);
    check_eq("rst_mid_busy", 64'(busy_o), 64'd0);
    check_eq("rst_mid_valid", 64'(valid_o), 64'd0);
    rst_ni = 1'b1;
    repeat (70) tick();
    do_op("after_rst", ALU_MULHU, 64'h8000_0000_0000_0000, 64'd4, 64'd2, 64, 0, 1'b0);

    check_eq("valid_pulses", 64'(rise_cnt), 64'(done_cnt));
    check_eq("result_zero_outside_done", 64'(zero_bad), 64'd0);
    check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiply_unit.md
MULTIPLY_UNIT -- requirements
Module: multiply_unit

Interface
REQ-001 The block SHALL expose parameter XLEN, default 64, meaning operand and result width.
REQ-002 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_ni  input  1  reset, synchronous and active-low.
REQ-004 valid_i  input  1  execute stage presents a multiply request this cycle.
REQ-005 alu_control_i  input  5  ALU control code from the ALU decoder.
REQ-006 src_a_i  input  XLEN  operand rs1.
REQ-007 src_b_i  input  XLEN  operand rs2.
REQ-008 flush_i  input  1  pipeline flush; aborts any in-flight operation.
REQ-009 stall_i  input  1  downstream stall; holds a completed result.
REQ-010 ready_o  output  1  unit can accept a request this cycle.
REQ-011 busy_o  output  1  operation in flight; used by the hazard unit to stall the pipeline.
REQ-012 valid_o  output  1  result_o holds a completed product.
REQ-013 result_o  output  XLEN  multiply result.

Function
REQ-014 Accepted codes SHALL be MUL 01111, MULH 10000, MULHSU 10001, MULHU 10010 and MULW 10111; any other code SHALL NOT be accepted, with no state change.
REQ-015 A request SHALL be accepted on a rising edge where valid_i, ready_o and a supported code are all high, and flush_i is low.
REQ-016 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-017 The FSM SHALL make these transitions: IDLE->BUSY on accept; BUSY->DONE after the last iteration; DONE->IDLE when stall_i is low; DONE holds while stall_i is high.
REQ-018 ready_o SHALL be high only in IDLE; busy_o SHALL be high in BUSY, and in DONE while stall_i is high.
REQ-019 Operand preparation at accept: the unit SHALL latch the magnitude of each operand and a negate flag.
REQ-020 Operand signedness: MUL, MULH and MULW SHALL treat both operands as signed; MULHSU SHALL treat A as signed and B as unsigned; MULHU SHALL treat both as unsigned.
REQ-021 MULW SHALL use only src_a_i[31:0] and src_b_i[31:0], taken as signed 32-bit values.
REQ-022 Datapath: radix-2 shift-add, one multiplier bit per cycle, into a 2*XLEN accumulator.
REQ-023 Iteration count N SHALL be XLEN for MUL, MULH, MULHSU and MULHU, and 32 for MULW.
REQ-024 Latency: with accept at edge T, valid_o SHALL rise in the cycle after edge T+N and be high only in DONE.
REQ-025 Final correction: the unit SHALL two's-complement the 2*XLEN product when the negate flag is set.
REQ-026 Result selection: MUL SHALL return product[XLEN-1:0]; MULH, MULHSU and MULHU SHALL return product[2*XLEN-1:XLEN]; MULW SHALL return sign-extended product[31:0].
REQ-027 result_o SHALL be stable while in DONE and SHALL be 0 when valid_o is low.
REQ-028 flush_i in BUSY or DONE SHALL force IDLE at the next edge with no valid_o.
REQ-029 flush_i SHALL have priority over accept in the same cycle.
REQ-030 Zero operands SHALL still take N cycles, with no early termination.
REQ-031 An operand equal to the most-negative value SHALL produce a correct magnitude: unsigned 2^(XLEN-1), no overflow.
REQ-032 valid_i while BUSY or DONE SHALL be ignored; the request is held upstream by the stall.

Reset
REQ-033 While rst_ni is low at a rising edge, the FSM SHALL go to IDLE and the counter, accumulator, operands and negate flag SHALL clear.
REQ-034 Reset values: ready_o=1 and busy_o=0, valid_o=0, result_o=0 from the first cycle after reset.
REQ-035 Reset asserted mid-operation SHALL discard the operation; no valid_o SHALL follow.

Structure
REQ-036 The five M-extension control codes and the FSM state enum SHALL live in the shared core package, which the ALU decoder also uses.
REQ-037 The unit SHALL contain one sub-module, mul_operand_prep: combinational sign handling, magnitude and negate-flag computation.
REQ-038 The counter width SHALL be clog2(XLEN)+1 bits.

Verification
REQ-039 MUL, A=3, B=-5 -> valid_o at cycle 65 after accept, result 0xFFFF_FFFF_FFFF_FFF1.
REQ-040 MULH, A=B=0x8000_0000_0000_0000 -> result 0x4000_0000_0000_0000.
REQ-041 MULHU, A=B=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE; MULHSU with the same operands -> 0xFFFF_FFFF_FFFF_FFFF.
REQ-042 MULW, A=0x7FFF_FFFF, B=2 -> valid_o at cycle 33, result 0xFFFF_FFFF_FFFF_FFFE.
REQ-043 flush_i at cycle 10 of BUSY -> IDLE next cycle, no valid_o; a new request accepted the following cycle completes correctly.
REQ-044 stall_i high for 3 cycles in DONE -> valid_o and result_o held 4 cycles; rst_ni low mid-BUSY -> ready_o=1 next cycle, valid_o never asserted.
